// File: rtl/vx_lmem_responder.sv
// Local-memory responder: accepts a multi-lane load/store request, services one lane per cycle
// against a word array, then returns load data for all lanes at once.
module vx_lmem_responder #(
   parameter int unsigned NUM_LANES  = 4,
   parameter int unsigned TAG_WIDTH  = 8,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned ADDR_WIDTH = 30
) (
   input  logic                            clk,
   input  logic                            reset,

   input  logic [NUM_LANES-1:0]            req_valid,
   input  logic                            req_rw,
   input  logic [NUM_LANES*4-1:0]          req_byteen,
   input  logic [NUM_LANES*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_LANES*32-1:0]         req_data,
   input  logic [TAG_WIDTH-1:0]            req_tag,
   output logic                            req_ready,

   output logic [NUM_LANES-1:0]            rsp_valid,
   output logic [NUM_LANES*32-1:0]         rsp_data,
   output logic [TAG_WIDTH-1:0]            rsp_tag,
   input  logic                            rsp_ready,

   output logic                            busy
);

   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   typedef enum logic [1:0] {StIdle, StBusy, StRsp} state_t;

   state_t                  state_q;
   logic                    rw_q;
   logic [NUM_LANES-1:0]    mask_q;
   logic [NUM_LANES-1:0]    pending_q;
   logic [TAG_WIDTH-1:0]    tag_q;
   logic [3:0]              byteen_q [NUM_LANES];
   logic [ADDR_WIDTH-1:0]   addr_q   [NUM_LANES];
   logic [31:0]             data_q   [NUM_LANES];
   logic [31:0]             rsp_data_q [NUM_LANES];
   logic [NUM_LANES-1:0]    rsp_valid_q;
   logic [TAG_WIDTH-1:0]    rsp_tag_q;

   logic [31:0]             mem [DEPTH];

   logic                    fire;
   logic [LANE_W-1:0]       sel_lane;
   logic [NUM_LANES-1:0]    sel_onehot;
   logic                    sel_last;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [IDX_W-1:0]        sel_idx;
   logic [3:0]              sel_byteen;
   logic [31:0]             sel_wdata;
   logic [31:0]             rd_word;
   logic                    mem_we;
   logic                    unused_sel_addr;

   assign req_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign fire      = req_ready && (|req_valid);

   // Descending scan so the lowest set pending bit is the one that sticks.
   always_comb begin
      sel_lane = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            sel_lane = LANE_W'(i);
         end
      end
   end

   assign sel_onehot = NUM_LANES'(1) << sel_lane;
   assign sel_last   = ((pending_q & ~sel_onehot) == '0);

   assign sel_addr   = addr_q[sel_lane];
   assign sel_idx    = sel_addr[IDX_W-1:0];
   assign sel_byteen = byteen_q[sel_lane];
   assign sel_wdata  = data_q[sel_lane];
   assign rd_word    = mem[sel_idx];

   // Upper address bits only alias onto the array.
   assign unused_sel_addr = ^sel_addr;

   assign mem_we = (state_q == StBusy) && rw_q;

   // Storage is deliberately not reset; async reset forces StIdle so no further lanes write.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (sel_byteen[b]) begin
               mem[sel_idx][8*b +: 8] <= sel_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         rw_q        <= 1'b0;
         mask_q      <= '0;
         pending_q   <= '0;
         tag_q       <= '0;
         rsp_valid_q <= '0;
         rsp_tag_q   <= '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            byteen_q[i]   <= '0;
            addr_q[i]     <= '0;
            data_q[i]     <= '0;
            rsp_data_q[i] <= '0;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (fire) begin
                  rw_q      <= req_rw;
                  mask_q    <= req_valid;
                  pending_q <= req_valid;
                  tag_q     <= req_tag;
                  for (int i = 0; i < NUM_LANES; i++) begin
                     byteen_q[i]   <= req_byteen[4*i +: 4];
                     addr_q[i]     <= req_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
                     data_q[i]     <= req_data[32*i +: 32];
                     rsp_data_q[i] <= '0;
                  end
                  state_q <= StBusy;
               end
            end
            StBusy: begin
               pending_q[sel_lane] <= 1'b0;
               if (!rw_q) begin
                  rsp_data_q[sel_lane] <= rd_word;
               end
               if (sel_last) begin
                  if (rw_q) begin
                     state_q <= StIdle;
                  end else begin
                     rsp_valid_q <= mask_q;
                     rsp_tag_q   <= tag_q;
                     state_q     <= StRsp;
                  end
               end
            end
            StRsp: begin
               if (rsp_ready) begin
                  rsp_valid_q <= '0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_tag   = rsp_tag_q;

   always_comb begin
      rsp_data = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         rsp_data[32*i +: 32] = rsp_data_q[i];
      end
   end

endmodule

// File: tb/tb_vx_lmem_responder.sv
// Directed bench for vx_lmem_responder: store/load round trips, byte enables, latency,
// backpressure, address wrap and mid-operation reset.
module tb_vx_lmem_responder;

   localparam int unsigned NL    = 4;
   localparam int unsigned TW    = 8;
   localparam int unsigned DEPTH = 1024;
   localparam int unsigned AW    = 30;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [NL-1:0]  req_valid = '0;
   logic           req_rw = 1'b0;
   logic [NL*4-1:0]  req_byteen = '0;
   logic [NL*AW-1:0] req_addr = '0;
   logic [NL*32-1:0] req_data = '0;
   logic [TW-1:0]  req_tag = '0;
   logic           req_ready;
   logic [NL-1:0]  rsp_valid;
   logic [NL*32-1:0] rsp_data;
   logic [TW-1:0]  rsp_tag;
   logic           rsp_ready = 1'b0;
   logic           busy;

   int total = 0;
   int bad = 0;

   logic [AW-1:0] la [NL];
   logic [31:0]   ld [NL];

   vx_lmem_responder #(
      .NUM_LANES (NL),
      .TAG_WIDTH (TW),
      .DEPTH     (DEPTH),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_rw     (req_rw),
      .req_byteen (req_byteen),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .req_tag    (req_tag),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_tag    (rsp_tag),
      .rsp_ready  (rsp_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with req_ready high; returns at the negedge after the accept edge.
   task automatic send(input logic [NL-1:0] v, input logic rw, input logic [NL*4-1:0] be,
                       input logic [TW-1:0] tag);
      check("send_ready", 128'(req_ready), 128'(1));
      req_valid  = v;
      req_rw     = rw;
      req_byteen = be;
      req_tag    = tag;
      for (int i = 0; i < NL; i++) begin
         req_addr[i*AW +: AW] = la[i];
         req_data[i*32 +: 32] = ld[i];
      end
      @(negedge clk);
      req_valid = '0;
   endtask

   task automatic busy_phase(input int n, input string nm);
      for (int k = 0; k < n; k++) begin
         check({nm, "_ready_low"}, 128'(req_ready), 128'(0));
         check({nm, "_no_rsp"}, 128'(rsp_valid), 128'(0));
         @(negedge clk);
      end
   endtask

   task automatic rsp_ack(input string nm);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({nm, "_ack_ready"}, 128'(req_ready), 128'(1));
      check({nm, "_ack_valid"}, 128'(rsp_valid), 128'(0));
   endtask

   task automatic do_store(input logic [NL-1:0] v, input logic [NL*4-1:0] be, input int n,
                           input string nm);
      send(v, 1'b1, be, '0);
      busy_phase(n, nm);
      check({nm, "_done_ready"}, 128'(req_ready), 128'(1));
      check({nm, "_done_novalid"}, 128'(rsp_valid), 128'(0));
   endtask

   task automatic do_load(input logic [NL-1:0] v, input int n, input logic [TW-1:0] tag,
                          input logic [127:0] exp_data, input string nm);
      send(v, 1'b0, '0, tag);
      busy_phase(n, nm);
      check({nm, "_valid"}, 128'(rsp_valid), 128'(v));
      check({nm, "_data"}, rsp_data, exp_data);
      check({nm, "_tag"}, 128'(rsp_tag), 128'(tag));
      rsp_ack(nm);
   endtask

   initial begin
      for (int i = 0; i < NL; i++) begin
         la[i] = '0;
         ld[i] = '0;
      end

      // Reset values
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      check("rst_rsp_data", rsp_data, 128'(0));
      check("rst_rsp_tag", 128'(rsp_tag), 128'(0));
      reset = 1'b1;
      @(negedge clk);
      check("rst_ready", 128'(req_ready), 128'(1));

      // No valid bits: not a request
      req_rw = 1'b1;
      @(negedge clk);
      check("novalid_busy", 128'(busy), 128'(0));
      check("novalid_ready", 128'(req_ready), 128'(1));

      // Four-lane store then load, tag 0x5A
      for (int i = 0; i < NL; i++) begin
         la[i] = AW'(i);
         ld[i] = 32'hA0 + 32'(i);
      end
      do_store(4'b1111, 16'hFFFF, 4, "st4");
      do_load(4'b1111, 4, 8'h5A, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, "ld4");

      // Partial byte enables over an all-ones word
      la[1] = 30'd7;
      ld[1] = 32'hFFFF_FFFF;
      do_store(4'b0010, 16'h00F0, 1, "st_ff");
      ld[1] = 32'h1122_3344;
      do_store(4'b0010, 16'h0050, 1, "st_be");
      do_load(4'b0010, 1, 8'h21, {32'h0, 32'h0, 32'hFF22_FF44, 32'h0}, "ld_be");

      // Sparse mask: two lanes, inactive lanes zero
      la[1] = 30'd1;
      la[3] = 30'd3;
      do_load(4'b1010, 2, 8'h40, {32'hA3, 32'h0, 32'hA1, 32'h0}, "ld_sparse");

      // Same index from two lanes: higher lane wins
      la[0] = 30'd20;
      la[2] = 30'd20;
      ld[0] = 32'h1111_1111;
      ld[2] = 32'h2222_2222;
      do_store(4'b0101, 16'h0F0F, 2, "st_coll");
      do_load(4'b0001, 1, 8'h02, {96'h0, 32'h2222_2222}, "ld_coll");

      // Backpressure: response held for 10 cycles
      la[0] = 30'd2;
      send(4'b0001, 1'b0, '0, 8'h77);
      busy_phase(1, "bp");
      for (int k = 0; k < 10; k++) begin
         check("bp_valid", 128'(rsp_valid), 128'(4'b0001));
         check("bp_data", rsp_data, {96'h0, 32'hA2});
         check("bp_tag", 128'(rsp_tag), 128'(8'h77));
         check("bp_ready_low", 128'(req_ready), 128'(0));
         @(negedge clk);
      end
      rsp_ack("bp");

      // Back-to-back store right after the handshake, with address wrap
      la[0] = AW'(DEPTH + 5);
      ld[0] = 32'h55;
      do_store(4'b0001, 16'h000F, 1, "st_wrap");
      la[0] = 30'd5;
      do_load(4'b0001, 1, 8'h05, {96'h0, 32'h55}, "ld_wrap");

      // Reset after two of four store lanes serviced
      for (int i = 0; i < NL; i++) begin
         la[i] = 30'd40 + AW'(i);
         ld[i] = 32'hC0 + 32'(i);
      end
      do_store(4'b1111, 16'hFFFF, 4, "st_pre");
      for (int i = 0; i < NL; i++) begin
         ld[i] = 32'hD0 + 32'(i);
      end
      send(4'b1111, 1'b1, 16'hFFFF, '0);
      check("mid_busy", 128'(busy), 128'(1));
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst_busy", 128'(busy), 128'(0));
      check("mid_rst_valid", 128'(rsp_valid), 128'(0));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      do_load(4'b1111, 4, 8'h43, {32'hC3, 32'hC2, 32'hD1, 32'hD0}, "ld_mid");

      // Reset in RSP drops the response without a handshake
      la[0] = 30'd0;
      send(4'b0001, 1'b0, '0, 8'h09);
      busy_phase(1, "rsp_rst");
      check("rsp_rst_pre_valid", 128'(rsp_valid), 128'(4'b0001));
      reset = 1'b0;
      #1;
      check("rsp_rst_valid", 128'(rsp_valid), 128'(0));
      check("rsp_rst_tag", 128'(rsp_tag), 128'(0));
      check("rsp_rst_data", rsp_data, 128'(0));
      check("rsp_rst_busy", 128'(busy), 128'(0));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rsp_rst_ready", 128'(req_ready), 128'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
